// File: rtl/spad_quench_ctrl.sv
// rtl/spad_quench_ctrl.sv - event-driven SPAD active quench/hold-off/reset sequencer
// Optional feature macro: SPAD_EVT_COUNTER_EN adds photon_cnt/cnt_clr and the saturating counter.
module spad_quench_ctrl #(
  parameter int QUENCH_CYC = 25,
  parameter int HOLD_CYC   = 50,
`ifdef SPAD_EVT_COUNTER_EN
  parameter int RESET_CYC  = 25,
  parameter int CNT_W      = 16
`else
  parameter int RESET_CYC  = 25
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             avalanche,
`ifdef SPAD_EVT_COUNTER_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] photon_cnt,
`endif
  output logic             geiger_mode_en,
  output logic             quench,
  output logic             reset,
  output logic             busy,
  output logic             photon_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_QUENCH,
    S_HOLD,
    S_RESET
  } state_t;

  localparam logic [15:0] QUENCH_LD = 16'(QUENCH_CYC - 1);
  localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYC - 1);
  localparam logic [15:0] RESET_LD  = 16'(RESET_CYC - 1);

  state_t      state, state_nx;
  logic [15:0] dur, dur_nx;
  logic        s1, s2, s3;
  logic        av_edge;

  assign av_edge = s2 & ~s3;

  // Three-flop synchroniser on the asynchronous comparator output; runs in every state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= avalanche;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State and duration counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dur   <= 16'd0;
    end else begin
      state <= state_nx;
      dur   <= dur_nx;
    end
  end

  // Next-state logic; edges outside ARMED are simply ignored (dead time)
  always_comb begin
    state_nx = state;
    dur_nx   = dur;
    case (state)
      S_IDLE: begin
        if (enable) state_nx = S_ARMED;
      end
      S_ARMED: begin
        if (!enable) begin
          state_nx = S_IDLE;
        end else if (av_edge) begin
          state_nx = S_QUENCH;
          dur_nx   = QUENCH_LD;
        end
      end
      S_QUENCH: begin
        if (dur == 16'd0) begin
          state_nx = S_HOLD;
          dur_nx   = HOLD_LD;
        end else begin
          dur_nx = dur - 16'd1;
        end
      end
      S_HOLD: begin
        if (dur == 16'd0) begin
          state_nx = S_RESET;
          dur_nx   = RESET_LD;
        end else begin
          dur_nx = dur - 16'd1;
        end
      end
      S_RESET: begin
        if (dur == 16'd0) begin
          state_nx = enable ? S_ARMED : S_IDLE;
        end else begin
          dur_nx = dur - 16'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        dur_nx   = 16'd0;
      end
    endcase
  end

  // Outputs registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      geiger_mode_en <= 1'b0;
      quench         <= 1'b0;
      reset          <= 1'b0;
      busy           <= 1'b0;
      photon_pulse   <= 1'b0;
    end else begin
      geiger_mode_en <= (state_nx != S_IDLE);
      quench         <= (state_nx == S_QUENCH);
      reset          <= (state_nx == S_RESET);
      busy           <= (state_nx == S_QUENCH) || (state_nx == S_HOLD) || (state_nx == S_RESET);
      photon_pulse   <= (state == S_ARMED) && (state_nx == S_QUENCH);
    end
  end

`ifdef SPAD_EVT_COUNTER_EN
  // Saturating photon counter; a clear coincident with a pulse keeps that photon
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      photon_cnt <= '0;
    end else if (cnt_clr) begin
      photon_cnt <= photon_pulse ? CNT_W'(1) : '0;
    end else if (photon_pulse && (photon_cnt != {CNT_W{1'b1}})) begin
      photon_cnt <= photon_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_spad_quench_ctrl.sv
// tb/tb_spad_quench_ctrl.sv - directed self-checking bench for spad_quench_ctrl
module tb_spad_quench_ctrl;

  localparam int TB_CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n, enable, avalanche;
  logic geiger_mode_en, quench, reset, busy, photon_pulse;
`ifdef SPAD_EVT_COUNTER_EN
  logic                cnt_clr;
  logic [TB_CNT_W-1:0] photon_cnt;
  int                  exp_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

`ifdef SPAD_EVT_COUNTER_EN
  spad_quench_ctrl #(.QUENCH_CYC(25), .HOLD_CYC(50), .RESET_CYC(25), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .avalanche(avalanche),
    .cnt_clr(cnt_clr), .photon_cnt(photon_cnt),
    .geiger_mode_en(geiger_mode_en), .quench(quench), .reset(reset),
    .busy(busy), .photon_pulse(photon_pulse));
`else
  spad_quench_ctrl #(.QUENCH_CYC(25), .HOLD_CYC(50), .RESET_CYC(25)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .avalanche(avalanche),
    .geiger_mode_en(geiger_mode_en), .quench(quench), .reset(reset),
    .busy(busy), .photon_pulse(photon_pulse));
`endif

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise avalanche; quench/busy/photon_pulse must rise exactly two edges after first sample
  task automatic trigger(input string tag);
    avalanche = 1'b1;
    tick(2);
    n_cmp++;
    if (quench !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_early_quench: got %b want 0", tag, quench);
    end
    tick(1);
    n_cmp++;
    if ({quench, busy, photon_pulse, reset} !== 4'b1110) begin
      n_bad++;
      $display("FAIL %s_quench_rise: got q/b/p/r=%b want 1110", tag, {quench, busy, photon_pulse, reset});
    end
  endtask

  // Walk one sequence from its first QUENCH cycle, measuring phase lengths
  task automatic run_seq(input string tag, input int av_drop, input int av_rise, input int en_drop,
                         input bit exp_geiger);
    int qn, hn, rn, pn, both, c;
    qn = 0; hn = 0; rn = 0; pn = 0; both = 0; c = 0;
    while (busy === 1'b1 && c < 300) begin
      if (quench && reset) both++;
      if (quench) qn++;
      else if (reset) rn++;
      else hn++;
      if (photon_pulse) pn++;
      if (c == av_drop) avalanche = 1'b0;
      if (c == av_rise) avalanche = 1'b1;
      if (c == en_drop) enable = 1'b0;
      tick(1);
      c++;
    end
    n_cmp++;
    if (c >= 300) begin
      n_bad++;
      $display("FAIL %s_timeout: busy stuck after %0d cycles", tag, c);
    end
    n_cmp++;
    if (qn != 25) begin
      n_bad++;
      $display("FAIL %s_quench_width: got %0d want 25", tag, qn);
    end
    n_cmp++;
    if (hn != 50) begin
      n_bad++;
      $display("FAIL %s_hold_width: got %0d want 50", tag, hn);
    end
    n_cmp++;
    if (rn != 25) begin
      n_bad++;
      $display("FAIL %s_reset_width: got %0d want 25", tag, rn);
    end
    n_cmp++;
    if (pn != 1 || both != 0) begin
      n_bad++;
      $display("FAIL %s_pulse_overlap: pulses %0d want 1, overlap %0d want 0", tag, pn, both);
    end
    n_cmp++;
    if ({geiger_mode_en, quench, reset, photon_pulse} !== {exp_geiger, 3'b000}) begin
      n_bad++;
      $display("FAIL %s_end_state: got g/q/r/p=%b want %b000", tag,
               {geiger_mode_en, quench, reset, photon_pulse}, exp_geiger);
    end
`ifdef SPAD_EVT_COUNTER_EN
    if (exp_cnt < 3) exp_cnt++;
    n_cmp++;
    if (int'(photon_cnt) != exp_cnt) begin
      n_bad++;
      $display("FAIL %s_count: got %0d want %0d", tag, photon_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; avalanche = 1'b0;
`ifdef SPAD_EVT_COUNTER_EN
    cnt_clr = 1'b0;
    exp_cnt = 0;
`endif
    tick(3);
    n_cmp++;
    if ({geiger_mode_en, quench, reset, busy, photon_pulse} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000", {geiger_mode_en, quench, reset, busy, photon_pulse});
    end
`ifdef SPAD_EVT_COUNTER_EN
    n_cmp++;
    if (photon_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d want 0", photon_cnt);
    end
`endif
    rst_n = 1'b1;
    tick(2);
    n_cmp++;
    if (geiger_mode_en !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_geiger: got %b want 0", geiger_mode_en);
    end
    enable = 1'b1;
    tick(1);
    n_cmp++;
    if (geiger_mode_en !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL arm_latency: got g=%b b=%b want g=1 b=0", geiger_mode_en, busy);
    end
    tick(3);
  endtask

  task automatic test_single_photon;
    trigger("single");
    run_seq("single", 7, -1, -1, 1'b1);
  endtask

  task automatic test_dead_time;
    int retrig;
    trigger("dead");
    run_seq("dead", 30, 40, -1, 1'b1);
    retrig = 0;
    for (int i = 0; i < 10; i++) begin
      if (quench || busy) retrig++;
      tick(1);
    end
    n_cmp++;
    if (retrig != 0) begin
      n_bad++;
      $display("FAIL dead_no_retrigger: got %0d busy cycles want 0", retrig);
    end
    avalanche = 1'b0;
    tick(3);
    trigger("fresh");
    run_seq("fresh", 5, -1, -1, 1'b1);
  endtask

  task automatic test_disable_mid;
    avalanche = 1'b0;
    tick(3);
    trigger("disable");
    run_seq("disable", 2, -1, 4, 1'b0);
    avalanche = 1'b1;
    tick(4);
    n_cmp++;
    if ({geiger_mode_en, quench, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_ignores_avalanche: got g/q/b=%b want 000", {geiger_mode_en, quench, busy});
    end
    avalanche = 1'b0;
    enable = 1'b1;
    tick(4);
  endtask

  task automatic test_reset_mid_quench;
    trigger("rstq");
    tick(9);
    rst_n = 1'b0;
    tick(1);
    n_cmp++;
    if ({geiger_mode_en, quench, reset, busy, photon_pulse} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_mid_quench: got %b want 00000", {geiger_mode_en, quench, reset, busy, photon_pulse});
    end
`ifdef SPAD_EVT_COUNTER_EN
    exp_cnt = 0;
    n_cmp++;
    if (photon_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_count: got %0d want 0", photon_cnt);
    end
`endif
    avalanche = 1'b0;
    rst_n = 1'b1;
    tick(4);
  endtask

`ifdef SPAD_EVT_COUNTER_EN
  task automatic test_counter;
    int c;
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    exp_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      trigger("sat");
      run_seq("sat", 2, -1, -1, 1'b1);
      tick(3);
    end
    n_cmp++;
    if (photon_cnt !== 2'd3) begin
      n_bad++;
      $display("FAIL count_saturate: got %0d want 3", photon_cnt);
    end
    trigger("clr");
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    avalanche = 1'b0;
    n_cmp++;
    if (photon_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL clear_with_pulse: got %0d want 1", photon_cnt);
    end
    c = 0;
    while (busy === 1'b1 && c < 300) begin
      tick(1);
      c++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_photon();
    test_dead_time();
    test_disable_mid();
    test_reset_mid_quench();
`ifdef SPAD_EVT_COUNTER_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
